i2c_reg_sequencer: RTL
======================

Name: i2c_reg_sequencer

Overview:
Hardware sequencer that runs complete I2C register transactions (device address, register address, one data byte) on an I2C byte-level master controller. No processor has to step the start/write/read/stop commands. It sits between a simple request/response user port and the byte controller's command interface. It reports completion status: OK, slave NACK, arbitration lost, or timeout.

Parameters:
TIMEOUT_CYCLES, 100000, max clk cycles one byte command may wait for i_cmd_ack before abort; 0 disables the timeout.
TIMEOUT_WIDTH, 17, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
i_req_valid  in  1  transaction request
o_req_ready  out  1  high only in IDLE
i_req_rnw  in  1  1 = read, 0 = write
i_req_dev_addr  in  7  7-bit slave address
i_req_reg_addr  in  8  register address byte
i_req_wr_data  in  8  write data byte
o_rsp_valid  out  1  response available; held until accepted
i_rsp_ready  in  1  response accept
o_rsp_status  out  2  0 OK, 1 NACK, 2 ARB_LOST, 3 TIMEOUT
o_rsp_rd_data  out  8  read byte; 0 on write or on error
o_busy  out  1  high from request accept until response accepted
o_start  out  1  byte ctrl: generate (repeated) START
o_stop  out  1  byte ctrl: generate STOP
o_read  out  1  byte ctrl: read byte
o_write  out  1  byte ctrl: write byte
o_ack_in  out  1  byte ctrl: ACK bit driven on read (1 = NACK)
o_din  out  8  byte ctrl: byte to transmit
o_core_reset  out  1  one-cycle pulse that resets the byte ctrl after timeout
i_cmd_ack  in  1  byte ctrl: command complete strobe
i_ack_out  in  1  byte ctrl: received ACK (1 = slave NACKed)
i_dout  in  8  byte ctrl: received byte
i_al  in  1  byte ctrl: arbitration lost strobe

Behaviour:
- Reset values:
  - All outputs 0 except o_req_ready = 1.
  - State = IDLE.
  - Latched request fields = 0.
  - Timeout counter = 0.
- Request handshake:
  - A request is accepted on the cycle where i_req_valid & o_req_ready are both high.
  - Address and data fields are latched on that cycle.
  - o_req_ready falls the next cycle and the first command is asserted the next cycle.
- Command rules:
  - o_start/o_stop/o_read/o_write/o_din/o_ack_in are set on entry to a command state.
  - They stay stable until i_cmd_ack is sampled high.
  - All command bits clear in the cycle after i_cmd_ack; the next command asserts one cycle later (one idle cycle between commands).
- States and commands:
  - IDLE
  - W_DEV: start + write, din = {dev, 0}
  - W_REG: write, din = reg
  - W_DATA: write + stop, din = wr_data
  - R_DEV: start + write, din = {dev, 1}
  - R_DATA: read + stop, ack_in = 1
  - NACK_STOP: stop only
  - RESP
- Write transaction path: IDLE -> W_DEV -> W_REG -> W_DATA -> RESP.
- Read transaction path: IDLE -> W_DEV -> W_REG -> R_DEV -> R_DATA -> RESP.
  - o_rsp_rd_data = i_dout, captured on the R_DATA i_cmd_ack cycle.
- NACK handling:
  - After a write-type command's i_cmd_ack, i_ack_out = 1 means the slave NACKed.
  - If that command carried no stop, go to NACK_STOP, then RESP with status 1.
  - If the NACK is on W_DATA (stop already issued), go to RESP with status 1 directly.
- Arbitration lost:
  - i_al in any command state goes to RESP with status 2; no STOP is issued.
  - i_al takes priority over a coincident i_cmd_ack and over NACK.
- Timeout:
  - The counter clears on every command entry and increments each cycle the command waits.
  - Reaching TIMEOUT_CYCLES with no ack and no i_al triggers the abort:
    - clear all command bits;
    - pulse o_core_reset for 1 cycle;
    - go to RESP with status 3.
  - If the timeout and i_cmd_ack coincide, the ack wins.
  - A timeout inside NACK_STOP reports 3, not 1.
- RESP:
  - o_rsp_valid is high and o_rsp_status/o_rsp_rd_data are stable until i_rsp_ready.
  - Return to IDLE the cycle after the response handshake; o_rsp_valid drops the same edge.
  - A new request cannot be accepted before IDLE (no overlap).
- Ignored inputs: i_cmd_ack, i_al and i_ack_out are ignored in IDLE and RESP.
- Reset mid-transaction: all state and outputs return asynchronously to reset values, with no response. The byte ctrl is reset by its own reset.

Test Plan:
1. Write: dev 0x50, reg 0x10, data 0xA5, model ACKs everything -> o_din sequence 0xA0, 0x10, 0xA5; start on byte 1 only, stop on byte 3 only; status 0; rd_data 0x00.
2. Read: dev 0x50, reg 0x22, model returns 0x3C -> o_din 0xA0, 0x22, 0xA1; start on bytes 1 and 3; final read has ack_in = 1 and stop; status 0; rd_data 0x3C.
3. NACK on the first byte (i_ack_out = 1) -> a stop-only command follows, no W_REG; status 1; o_req_ready returns after i_rsp_ready.
4. i_al pulsed during W_REG, coincident with i_cmd_ack -> no further commands, no stop; status 2.
5. TIMEOUT_CYCLES = 50, model never acks -> exactly one o_core_reset pulse 50 cycles after command entry; status 3; then a normal write succeeds.
6. rst asserted mid R_DEV -> all command outputs 0 immediately, o_req_ready = 1, no o_rsp_valid; hold i_rsp_ready low in a later transaction -> response stays stable for 20 cycles.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// rtl/i2c_reg_sequencer.sv - runs one I2C register read/write transaction on a byte-level master
// Issues START/WRITE/READ/STOP commands to the byte controller and reports OK, NACK, ARB_LOST or TIMEOUT.
module i2c_reg_sequencer #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_WIDTH  = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_rnw,
  input  logic [6:0] i_req_dev_addr,
  input  logic [7:0] i_req_reg_addr,
  input  logic [7:0] i_req_wr_data,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [1:0] o_rsp_status,
  output logic [7:0] o_rsp_rd_data,
  output logic       o_busy,
  output logic       o_start,
  output logic       o_stop,
  output logic       o_read,
  output logic       o_write,
  output logic       o_ack_in,
  output logic [7:0] o_din,
  output logic       o_core_reset,
  input  logic       i_cmd_ack,
  input  logic       i_ack_out,
  input  logic [7:0] i_dout,
  input  logic       i_al
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_DEV, S_W_REG, S_W_DATA, S_R_DEV, S_R_DATA, S_NACK_STOP, S_RESP
  } state_t;

  localparam logic [1:0] ST_OK = 2'd0, ST_NACK = 2'd1, ST_ARB = 2'd2, ST_TMO = 2'd3;
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST =
    TIMEOUT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                   state;
  logic                     pending;  // command state entered, its command goes out next edge
  logic [TIMEOUT_WIDTH-1:0] timeout_cnt;
  logic                     rnw_q;
  logic [6:0]               dev_q;
  logic [7:0]               reg_q;
  logic [7:0]               data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      pending       <= 1'b0;
      timeout_cnt   <= '0;
      rnw_q         <= 1'b0;
      dev_q         <= '0;
      reg_q         <= '0;
      data_q        <= '0;
      o_req_ready   <= 1'b1;
      o_rsp_valid   <= 1'b0;
      o_rsp_status  <= ST_OK;
      o_rsp_rd_data <= '0;
      o_busy        <= 1'b0;
      o_start       <= 1'b0;
      o_stop        <= 1'b0;
      o_read        <= 1'b0;
      o_write       <= 1'b0;
      o_ack_in      <= 1'b0;
      o_din         <= '0;
      o_core_reset  <= 1'b0;
    end else begin
      o_core_reset <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            rnw_q         <= i_req_rnw;
            dev_q         <= i_req_dev_addr;
            reg_q         <= i_req_reg_addr;
            data_q        <= i_req_wr_data;
            o_req_ready   <= 1'b0;
            o_busy        <= 1'b1;
            o_rsp_status  <= ST_OK;
            o_rsp_rd_data <= '0;
            state         <= S_W_DEV;
            pending       <= 1'b0;
            timeout_cnt   <= '0;
            o_start       <= 1'b1;
            o_write       <= 1'b1;
            o_din         <= {i_req_dev_addr, 1'b0};
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          if (i_al) begin
            {o_start, o_stop, o_read, o_write, o_ack_in} <= '0;
            o_din        <= '0;
            pending      <= 1'b0;
            state        <= S_RESP;
            o_rsp_valid  <= 1'b1;
            o_rsp_status <= ST_ARB;
          end else if (pending) begin
            pending     <= 1'b0;
            timeout_cnt <= '0;
            case (state)
              S_W_REG:     begin o_write <= 1'b1; o_din <= reg_q; end
              S_W_DATA:    begin o_write <= 1'b1; o_stop <= 1'b1; o_din <= data_q; end
              S_R_DEV:     begin o_start <= 1'b1; o_write <= 1'b1; o_din <= {dev_q, 1'b1}; end
              S_R_DATA:    begin o_read <= 1'b1; o_stop <= 1'b1; o_ack_in <= 1'b1; end
              S_NACK_STOP: o_stop <= 1'b1;
              default:     begin o_start <= 1'b1; o_write <= 1'b1; o_din <= {dev_q, 1'b0}; end
            endcase
          end else if (i_cmd_ack) begin
            {o_start, o_stop, o_read, o_write, o_ack_in} <= '0;
            o_din <= '0;
            case (state)
              S_W_DEV: begin
                state   <= i_ack_out ? S_NACK_STOP : S_W_REG;
                pending <= 1'b1;
              end
              S_W_REG: begin
                state   <= i_ack_out ? S_NACK_STOP : (rnw_q ? S_R_DEV : S_W_DATA);
                pending <= 1'b1;
              end
              S_R_DEV: begin
                state   <= i_ack_out ? S_NACK_STOP : S_R_DATA;
                pending <= 1'b1;
              end
              S_W_DATA: begin
                state        <= S_RESP;
                o_rsp_valid  <= 1'b1;
                o_rsp_status <= i_ack_out ? ST_NACK : ST_OK;
              end
              S_R_DATA: begin
                state         <= S_RESP;
                o_rsp_valid   <= 1'b1;
                o_rsp_status  <= ST_OK;
                o_rsp_rd_data <= i_dout;
              end
              default: begin
                state        <= S_RESP;
                o_rsp_valid  <= 1'b1;
                o_rsp_status <= ST_NACK;
              end
            endcase
          end else if ((TIMEOUT_CYCLES != 0) && (timeout_cnt == TO_LAST)) begin
            {o_start, o_stop, o_read, o_write, o_ack_in} <= '0;
            o_din        <= '0;
            o_core_reset <= 1'b1;
            state        <= S_RESP;
            o_rsp_valid  <= 1'b1;
            o_rsp_status <= ST_TMO;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
